// File: rtl/cpu_pkg.sv
// Shared processor definitions: opcodes, fetch FSM states and default widths.
package cpu_pkg;

  localparam int CPU_ADDR_W = 7;
  localparam int CPU_DATA_W = 16;

  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;

  typedef enum logic {F_LOAD, F_RUN} fetch_state_t;

endpackage

// File: rtl/instr_ram_sp.sv
// Instruction memory: one write port, one synchronous read port, no reset.
module instr_ram_sp #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rd_q
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge Clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rd_q <= mem[raddr];
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: program-load / run FSM, PC, IR and status pulses around the instruction RAM.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int          ADDR_W   = CPU_ADDR_W,
  parameter int          DATA_W   = CPU_DATA_W,
  parameter int unsigned START_PC = 0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              PC_clr,
  input  logic              PC_up,
  input  logic              IR_id,
  input  logic              Ld_en,
  input  logic [ADDR_W-1:0] Ld_addr,
  input  logic [DATA_W-1:0] Ld_data,
  input  logic              Ld_done,
  output logic [DATA_W-1:0] IR,
  output logic [ADDR_W-1:0] PC,
  output logic              IR_valid,
  output logic              Running,
  output logic              Wrap,
  output logic              Ld_err
);

  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(START_PC);

  fetch_state_t      state_q, state_d;
  logic              run;
  logic [DATA_W-1:0] rd_q;

  assign run     = (state_q == F_RUN);
  assign Running = run;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= F_LOAD;
    else       state_q <= state_d;
  end

  // LOAD -> RUN is one-way; only Reset brings the unit back to LOAD.
  always_comb begin
    state_d = state_q;
    if (state_q == F_LOAD && Ld_done) state_d = F_RUN;
  end

  instr_ram_sp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .Clock (Clock),
    .we    (!run && Ld_en),
    .waddr (Ld_addr),
    .wdata (Ld_data),
    .re    (run),
    .raddr (PC),
    .rd_q  (rd_q)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      PC       <= PC_RST;
      IR       <= '0;
      IR_valid <= 1'b0;
      Wrap     <= 1'b0;
      Ld_err   <= 1'b0;
    end else begin
      Wrap   <= 1'b0;
      Ld_err <= 1'b0;
      if (run) begin
        Ld_err <= Ld_en;
        if (PC_clr) PC <= PC_RST;
        else if (PC_up) begin
          PC   <= PC + 1'b1;
          Wrap <= &PC;
        end
        // A capture in the same cycle as PC_clr leaves IR_valid set.
        if (IR_id) begin
          IR       <= rd_q;
          IR_valid <= 1'b1;
        end else if (PC_clr) begin
          IR_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed sequence then random traffic, two widths, against a cycle model.
module tb_instr_fetch_unit;

  logic        Clock = 1'b0;
  logic        Reset, PC_clr, PC_up, IR_id, Ld_en, Ld_done;
  logic [6:0]  Ld_addr;
  logic [15:0] Ld_data;

  logic [15:0] IR_w, IR_n;
  logic [6:0]  PC_w;
  logic [2:0]  PC_n;
  logic        IRv_w, IRv_n, Run_w, Run_n, Wrap_w, Wrap_n, Err_w, Err_n;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 Clock = ~Clock;

  instr_fetch_unit dut (
    .Clock(Clock), .Reset(Reset), .PC_clr(PC_clr), .PC_up(PC_up), .IR_id(IR_id),
    .Ld_en(Ld_en), .Ld_addr(Ld_addr), .Ld_data(Ld_data), .Ld_done(Ld_done),
    .IR(IR_w), .PC(PC_w), .IR_valid(IRv_w), .Running(Run_w), .Wrap(Wrap_w), .Ld_err(Err_w)
  );

  instr_fetch_unit #(.ADDR_W(3)) dut_n (
    .Clock(Clock), .Reset(Reset), .PC_clr(PC_clr), .PC_up(PC_up), .IR_id(IR_id),
    .Ld_en(Ld_en), .Ld_addr(Ld_addr[2:0]), .Ld_data(Ld_data), .Ld_done(Ld_done),
    .IR(IR_n), .PC(PC_n), .IR_valid(IRv_n), .Running(Run_n), .Wrap(Wrap_n), .Ld_err(Err_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: index 0 = 128-word unit, index 1 = 8-word unit.
  int unsigned dep [2] = '{128, 8};
  int unsigned mmem [2][128];
  bit          mmk  [2][128];
  int unsigned mpc [2], mir [2], mrd [2];
  bit          mirv [2], mirk [2], mrdk [2], mrun [2], mwrap [2], merr [2];

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      mpc[k] = 0; mir[k] = 0; mirk[k] = 1; mirv[k] = 0;
      mrun[k] = 0; mwrap[k] = 0; merr[k] = 0;
    end
  endtask

  task automatic mstep();
    int unsigned a, nrd;
    bit nrdk;
    if (Reset) begin mreset(); return; end
    for (int k = 0; k < 2; k++) begin
      a = int'(Ld_addr) % dep[k];
      if (mrun[k]) begin
        nrd  = mmem[k][mpc[k]];
        nrdk = mmk[k][mpc[k]];
        if (IR_id) begin mir[k] = mrd[k]; mirk[k] = mrdk[k]; mirv[k] = 1; end
        else if (PC_clr) mirv[k] = 0;
        merr[k]  = Ld_en;
        mwrap[k] = !PC_clr && PC_up && (mpc[k] == dep[k] - 1);
        if (PC_clr) mpc[k] = 0;
        else if (PC_up) mpc[k] = (mpc[k] + 1) % dep[k];
        mrd[k] = nrd; mrdk[k] = nrdk;
      end else begin
        merr[k] = 0; mwrap[k] = 0;
        if (Ld_en) begin mmem[k][a] = int'(Ld_data); mmk[k][a] = 1; end
        if (Ld_done) mrun[k] = 1;
      end
    end
  endtask

  task automatic cmp_one(input int k, input logic [31:0] pc, ir, irv, run, wrap, err);
    string s;
    s = (k == 0) ? "w7_" : "w3_";
    check({s, "pc"}, pc, mpc[k]);
    check({s, "irv"}, irv, 32'(mirv[k]));
    check({s, "run"}, run, 32'(mrun[k]));
    check({s, "wrap"}, wrap, 32'(mwrap[k]));
    check({s, "lderr"}, err, 32'(merr[k]));
    if (mirk[k]) check({s, "ir"}, ir, mir[k]);
  endtask

  task automatic cmp();
    cmp_one(0, 32'(PC_w), 32'(IR_w), 32'(IRv_w), 32'(Run_w), 32'(Wrap_w), 32'(Err_w));
    cmp_one(1, 32'(PC_n), 32'(IR_n), 32'(IRv_n), 32'(Run_n), 32'(Wrap_n), 32'(Err_n));
  endtask

  // Called at a negedge: drive, clock, update model, check, return at next negedge.
  task automatic step(input bit clr, up, id, len, input logic [6:0] la,
                      input logic [15:0] ld, input bit done);
    PC_clr = clr; PC_up = up; IR_id = id; Ld_en = len; Ld_addr = la; Ld_data = ld; Ld_done = done;
    @(posedge Clock);
    mstep();
    #1 cmp();
    @(negedge Clock);
  endtask

  task automatic idle(); step(0, 0, 0, 0, 7'd0, 16'h0, 0); endtask

  task automatic async_reset();
    Reset = 1'b1;
    mreset();
    #1 cmp();
    check("rst_pc", 32'(PC_w), 32'd0);
    check("rst_ir", 32'(IR_w), 32'd0);
    check("rst_irv", 32'(IRv_w), 32'd0);
    check("rst_run", 32'(Run_w), 32'd0);
    @(negedge Clock);
    idle();
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; PC_clr = 0; PC_up = 0; IR_id = 0; Ld_en = 0; Ld_done = 0;
    Ld_addr = '0; Ld_data = '0;
    mreset();
    @(negedge Clock);
    idle(); idle();
    Reset = 1'b0;

    // Program load, then fetch word 0
    step(0, 0, 0, 1, 7'd0, 16'h0731, 0);
    step(1, 1, 1, 1, 7'd1, 16'h1731, 0);   // controller strobes ignored in LOAD
    step(0, 0, 0, 1, 7'd2, 16'h2731, 0);
    step(0, 0, 0, 0, 7'd0, 16'h0, 1);
    check("t2_running", 32'(Run_w), 32'd1);
    step(1, 0, 0, 0, 7'd0, 16'h0, 0);
    idle();
    step(0, 0, 1, 0, 7'd0, 16'h0, 0);
    check("t2_ir", 32'(IR_w), 32'h0731);
    check("t2_irv", 32'(IRv_w), 32'd1);

    // Sequential fetch and IR hold
    for (int i = 1; i <= 2; i++) begin
      step(0, 1, 0, 0, 7'd0, 16'h0, 0);
      idle();
      step(0, 0, 1, 0, 7'd0, 16'h0, 0);
      check("t3_pc", 32'(PC_w), 32'(i));
      check("t3_ir", 32'(IR_w), (i == 1) ? 32'h1731 : 32'h2731);
    end
    idle(); idle();
    check("t3_hold", 32'(IR_w), 32'h2731);

    // PC_clr beats PC_up; IR_id with PC_clr keeps IR_valid set
    step(1, 1, 1, 0, 7'd0, 16'h0, 0);
    check("clr_up_pc", 32'(PC_w), 32'd0);
    check("clr_id_irv", 32'(IRv_w), 32'd1);

    // Narrow unit wraps after 8 increments; wide unit wraps after 128
    repeat (7) step(0, 1, 0, 0, 7'd0, 16'h0, 0);
    check("t4_pc7", 32'(PC_n), 32'd7);
    step(0, 1, 0, 0, 7'd0, 16'h0, 0);
    check("t4_pc0", 32'(PC_n), 32'd0);
    check("t4_wrap", 32'(Wrap_n), 32'd1);
    idle();
    check("t4_wrap_end", 32'(Wrap_n), 32'd0);
    repeat (120) step(0, 1, 0, 0, 7'd0, 16'h0, 0);
    check("t4_wide_wrap", 32'(Wrap_w), 32'd1);

    // Load attempt while running
    step(0, 0, 0, 1, 7'd0, 16'hFFFF, 0);
    check("t5_lderr", 32'(Err_w), 32'd1);
    idle();
    check("t5_lderr_end", 32'(Err_w), 32'd0);
    step(1, 0, 0, 0, 7'd0, 16'h0, 0);
    idle();
    step(0, 0, 1, 0, 7'd0, 16'h0, 0);
    check("t5_ir", 32'(IR_w), 32'h0731);

    // Reset mid-run; memory survives
    step(0, 1, 0, 0, 7'd0, 16'h0, 0);
    async_reset();
    step(0, 1, 0, 0, 7'd0, 16'h0, 0);
    check("t6_pc_ignored", 32'(PC_w), 32'd0);
    step(0, 0, 0, 0, 7'd0, 16'h0, 1);
    step(0, 1, 0, 0, 7'd0, 16'h0, 0);
    idle();
    step(0, 0, 1, 0, 7'd0, 16'h0, 0);
    check("t6_ir", 32'(IR_w), 32'h1731);

    // Write and Ld_done in the same cycle
    async_reset();
    step(0, 0, 0, 1, 7'd0, 16'h3C3C, 1);
    check("wd_running", 32'(Run_w), 32'd1);
    idle();
    step(0, 0, 1, 0, 7'd0, 16'h0, 0);
    check("wd_ir", 32'(IR_w), 32'h3C3C);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) async_reset();
      step($urandom_range(7) == 0, $urandom_range(1) == 0, $urandom_range(2) == 0,
           Run_w ? ($urandom_range(15) == 0) : ($urandom_range(1) == 0),
           7'($urandom), 16'($urandom), $urandom_range(5) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
